// File: rtl/ddr4_v2_2_20_axi_pkg.sv
// Shared types and limits for the AXI->MC command path.
package ddr4_v2_2_20_axi_pkg;

  localparam int C_MAX_OUTSTANDING_LIMIT = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CMD       = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_DONE      = 2'd3
  } cmd_fsm_state_t;

  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/ddr4_v2_2_20_axi_credit_cnt.sv
// Up/down response-slot counter with saturation and a sticky underflow flag.
module ddr4_v2_2_20_axi_credit_cnt
  import ddr4_v2_2_20_axi_pkg::*;
#(
  parameter int C_MAX = 4,
  parameter int C_W   = cnt_width(C_MAX)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           inc,
  input  logic           dec,
  output logic [C_W-1:0] count,
  output logic           underflow_err
);

  localparam logic [C_W-1:0] MAX_VAL = C_W'(C_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count         <= '0;
      underflow_err <= 1'b0;
    end else begin
      // A retire with nothing outstanding is a downstream bug; remember it.
      if (dec && (count == '0)) underflow_err <= 1'b1;
      if (inc && !dec && (count != MAX_VAL)) begin
        count <= count + C_W'(1);
      end else if (dec && !inc && (count != '0)) begin
        count <= count - C_W'(1);
      end
    end
  end

endmodule

// File: rtl/ddr4_v2_2_20_axi_cmd_fsm_credit.sv
// Credit-limited AXI->MC command FSM: issues one or more MC commands per AXI
// transaction and pulses axready once the last one is accepted.
module ddr4_v2_2_20_axi_cmd_fsm_credit
  import ddr4_v2_2_20_axi_pkg::*;
#(
  parameter int C_MC_BURST_LEN    = 1,
  parameter int C_MC_RD_INST      = 0,
  parameter int C_MAX_OUTSTANDING = 4,
  localparam int C_CNT_WIDTH      = $clog2(C_MAX_OUTSTANDING + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   axvalid,
  output logic                   axready,
  output logic                   cmd_en,
  input  logic                   cmd_full,
  output logic                   next,
  input  logic                   next_pending,
  input  logic                   data_rdy,
  output logic                   cmd_en_last,
  output logic                   resp_push,
  input  logic                   resp_pop,
  output logic [C_CNT_WIDTH-1:0] outstanding,
  output logic                   underflow_err,
  output logic [1:0]             fsm_state
);

  localparam logic [1:0] IDLE      = ST_IDLE;
  localparam logic [1:0] CMD       = ST_CMD;
  localparam logic [1:0] WAIT_DATA = ST_WAIT_DATA;
  localparam logic [1:0] DONE      = ST_DONE;

  if (C_MC_BURST_LEN < 1 || C_MC_BURST_LEN > 2 || C_MC_RD_INST < 0 || C_MC_RD_INST > 1 ||
      C_MAX_OUTSTANDING < 1 || C_MAX_OUTSTANDING > C_MAX_OUTSTANDING_LIMIT) begin : g_param_check
    $error("ddr4_v2_2_20_axi_cmd_fsm_credit: parameter out of range");
  end

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       cmd_en_nxt;
  logic       credit_ok;

  // Handshake: an MC command transfers on any cycle where cmd_en=1 and cmd_full=0;
  // cmd_en never drops before that. AXI address transfers on the axready pulse.
  assign next        = cmd_en & ~cmd_full;
  assign cmd_en_last = next & ~next_pending;
  assign resp_push   = cmd_en_last;
  assign axready     = (state == DONE);
  assign fsm_state   = state;

  // A slot retired this cycle is already usable for a new transaction.
  assign credit_ok = (outstanding < C_CNT_WIDTH'(C_MAX_OUTSTANDING)) ||
                     (resp_pop && (outstanding != '0));

  always_comb begin
    state_nxt  = state;
    cmd_en_nxt = cmd_en;
    case (state)
      IDLE: begin
        if (axvalid && data_rdy && credit_ok) begin
          state_nxt  = CMD;
          cmd_en_nxt = 1'b1;
        end
      end
      CMD: begin
        if (next) begin
          if (!next_pending) begin
            state_nxt  = DONE;
            cmd_en_nxt = 1'b0;
          end else if (!data_rdy) begin
            state_nxt  = WAIT_DATA;
            cmd_en_nxt = 1'b0;
          end
        end
      end
      WAIT_DATA: begin
        if (data_rdy) begin
          state_nxt  = CMD;
          cmd_en_nxt = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt  = IDLE;
        cmd_en_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cmd_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      cmd_en <= cmd_en_nxt;
    end
  end

  ddr4_v2_2_20_axi_credit_cnt #(
    .C_MAX (C_MAX_OUTSTANDING),
    .C_W   (C_CNT_WIDTH)
  ) u_credit_cnt (
    .clk           (clk),
    .reset_n       (reset_n),
    .inc           (resp_push),
    .dec           (resp_pop),
    .count         (outstanding),
    .underflow_err (underflow_err)
  );

endmodule

// File: tb/tb_ddr4_v2_2_20_axi_cmd_fsm_credit.sv
// Bench for the credit-limited AXI command FSM: directed scenarios plus random
// traffic, all checked against a transaction-level reference model.
module tb_ddr4_v2_2_20_axi_cmd_fsm_credit;

  localparam int MAX = 4;
  localparam int CW  = $clog2(MAX + 1);

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic          axvalid = 1'b0, cmd_full = 1'b0, next_pending = 1'b0;
  logic          data_rdy = 1'b0, resp_pop = 1'b0;
  logic          axready, cmd_en, next, cmd_en_last, resp_push, underflow_err;
  logic [CW-1:0] outstanding;
  logic [1:0]    fsm_state;

  ddr4_v2_2_20_axi_cmd_fsm_credit #(
    .C_MC_BURST_LEN    (1),
    .C_MC_RD_INST      (0),
    .C_MAX_OUTSTANDING (MAX)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .axvalid       (axvalid),
    .axready       (axready),
    .cmd_en        (cmd_en),
    .cmd_full      (cmd_full),
    .next          (next),
    .next_pending  (next_pending),
    .data_rdy      (data_rdy),
    .cmd_en_last   (cmd_en_last),
    .resp_push     (resp_push),
    .resp_pop      (resp_pop),
    .outstanding   (outstanding),
    .underflow_err (underflow_err),
    .fsm_state     (fsm_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: txn in flight, command offered, done pulse, slots in use
  bit m_active, m_cmd_en, m_ax, m_err;
  int m_out;
  int tx_left, cur_k, nexts_seen;
  int cnt_next, cnt_last, cnt_ax;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_active = 0; m_cmd_en = 0; m_ax = 0; m_err = 0; m_out = 0;
    tx_left = 0; nexts_seen = 0;
    exp_q.delete();
    axvalid = 0; data_rdy = 0; cmd_full = 0; resp_pop = 0;
  endtask

  // One clock: called at posedge+1 with inputs set; returns at next posedge+1.
  task automatic step();
    bit acc, last, ok;
    next_pending = (tx_left > 1);
    #2;
    acc  = m_cmd_en && !cmd_full;
    last = acc && !next_pending;
    check("next", next, acc);
    check("cmd_en_last", cmd_en_last, last);
    check("resp_push", resp_push, last);
    if (next) begin nexts_seen++; cnt_next++; end
    if (cmd_en_last) begin
      cnt_last++;
      check("sb_q_depth", exp_q.size(), 1);
      if (exp_q.size() != 0) check("sb_cmds_per_txn", nexts_seen, exp_q.pop_front());
      nexts_seen = 0;
    end
    ok = (m_out < MAX) || (resp_pop && m_out > 0);
    if (m_ax) begin
      m_ax = 0; m_active = 0;
    end else if (!m_active) begin
      if (axvalid && data_rdy && ok) begin
        m_active = 1; m_cmd_en = 1;
        exp_q.push_back(cur_k);
      end
    end else if (acc) begin
      if (!next_pending) begin m_cmd_en = 0; m_ax = 1; end
      else if (!data_rdy) m_cmd_en = 0;
    end else if (!m_cmd_en && data_rdy) begin
      m_cmd_en = 1;
    end
    if (resp_pop && m_out == 0) m_err = 1;
    if (last && !resp_pop && m_out < MAX) m_out++;
    else if (resp_pop && !last && m_out > 0) m_out--;
    @(posedge clk);
    #1;
    if (acc && tx_left > 0) tx_left--;
    check("cmd_en", cmd_en, m_cmd_en);
    check("axready", axready, m_ax);
    check("outstanding", outstanding, m_out);
    check("underflow_err", underflow_err, m_err);
    if (axready) cnt_ax++;
  endtask

  // Asynchronous reset between clock edges; outputs must clear with no edge.
  task automatic do_reset();
    reset_n = 0;
    #1;
    check("arst_cmd_en", cmd_en, 0);
    check("arst_axready", axready, 0);
    check("arst_outstanding", outstanding, 0);
    check("arst_underflow", underflow_err, 0);
    reset_model();
    #2;
    reset_n = 1;
  endtask

  task automatic run_txn(input int k);
    cur_k = k; tx_left = k; axvalid = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (axready) break;
    end
    check("txn_done_in_budget", axready, 1);
    step();
    axvalid = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bit done_pend;
    reset_model();
    #1 reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_en", cmd_en, 0);
    check("rst_axready", axready, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_underflow", underflow_err, 0);
    check("rst_state", fsm_state, 0);
    reset_n = 1;

    // single-command txn latency, then next txn starting at N+4
    data_rdy = 1; cmd_full = 0; cur_k = 1; tx_left = 1; axvalid = 1;
    step();
    check("t1_cmd_en_n1", cmd_en, 1);
    step();
    check("t1_axready_n2", axready, 1);
    check("t1_out_n2", outstanding, 1);
    cur_k = 1; tx_left = 1;
    step();
    step();
    check("t1_cmd_en_n4", cmd_en, 1);
    step(); step();
    axvalid = 0;

    // back-pressure holds cmd_en
    cur_k = 1; tx_left = 1; axvalid = 1;
    step();
    cmd_full = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_cmd_en_held", cmd_en, 1);
      check("t2_no_next", next, 0);
    end
    cmd_full = 0;
    step();
    check("t2_axready", axready, 1);
    step();
    axvalid = 0;

    // four-command txn with a data stall after the second accept
    cnt_next = 0; cnt_last = 0; cnt_ax = 0; w = 0;
    cur_k = 4; tx_left = 4; axvalid = 1;
    for (int i = 0; i < 30; i++) begin
      if (tx_left == 3) data_rdy = 0;
      else if (tx_left == 2 && !m_cmd_en) begin data_rdy = (w >= 2); w++; end
      else data_rdy = 1;
      step();
      if (axready) break;
    end
    data_rdy = 1;
    step();
    axvalid = 0;
    check("t3_next_cnt", cnt_next, 4);
    check("t3_last_cnt", cnt_last, 1);
    check("t3_axready_cnt", cnt_ax, 1);

    // credit limit
    do_reset();
    data_rdy = 1; cnt_ax = 0;
    for (int i = 0; i < 4; i++) run_txn(1);
    check("t4_out_full", outstanding, 4);
    check("t4_axready_cnt", cnt_ax, 4);
    cur_k = 1; tx_left = 1; axvalid = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_blocked", cmd_en, 0);
    end
    resp_pop = 1;
    step();
    resp_pop = 0;
    check("t4_issue_after_pop", cmd_en, 1);
    check("t4_out_after_pop", outstanding, 3);
    resp_pop = 1;
    step();
    resp_pop = 0;
    check("t4_push_pop_hold", outstanding, 3);
    step();
    axvalid = 0;

    // underflow is sticky
    do_reset();
    resp_pop = 1;
    step();
    resp_pop = 0;
    check("t5_out_zero", outstanding, 0);
    check("t5_err_set", underflow_err, 1);
    repeat (3) step();
    check("t5_err_sticky", underflow_err, 1);

    // async reset in the middle of a held command
    data_rdy = 1;
    run_txn(1);
    cur_k = 2; tx_left = 2; axvalid = 1; cmd_full = 1;
    step(); step();
    check("t6_in_cmd", cmd_en, 1);
    do_reset();
    repeat (2) step();

    // random traffic
    done_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      if (done_pend) begin axvalid = 0; done_pend = 0; end
      if (m_ax) done_pend = 1;
      if (!axvalid && $urandom_range(0, 2) == 0) begin
        cur_k = $urandom_range(1, 4); tx_left = cur_k; axvalid = 1;
      end
      data_rdy = ($urandom_range(0, 3) != 0);
      cmd_full = ($urandom_range(0, 3) == 0);
      resp_pop = (m_out > 0) && ($urandom_range(0, 2) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
